id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and EX-stage operand builder, directly upstream of the ALU.
//  Latches decoded instructions and forwards from EX/MEM and MEM/WB.
//  Builds ALU operands: shamt for shifts, extended imm, LUI.
//  Drives reg_A/reg_B/alu_op/opcode_E and detects load-use hazards.
// PARAMETERS
//  DATA_W  32  datapath width
//  REG_AW  5   register-index width
// PORTS
//  CLK        in  1       clock, rising edge
//  RESET      in  1       synchronous, active-high
//  valid_D    in  1       ID holds a real instruction
//  opcode_D   in  6       instr[31:26]
//  funct_D    in  6       instr[5:0]
//  rs_D/rt_D/rd_D in 5    register indices
//  shamt_D    in  5       instr[10:6]
//  imm_D      in  16      instr[15:0]
//  rs_data_D/rt_data_D in DATA_W  register-file read data
//  alu_op_D   in  4       ALU op code from decoder
//  ctrl_D     in  5       {reg_write,mem_read,mem_write,mem_to_reg,alu_src}
//  flush_E    in  1       branch/jump redirect: kill ID/EX contents
//  exm_wr/exm_rd/exm_res in 1/5/DATA_W  EX/MEM forwarding source
//  mwb_wr/mwb_rd/mwb_data in 1/5/DATA_W MEM/WB forwarding source
//  reg_A/reg_B out DATA_W ALU operands (A = shift amount for shifts)
//  alu_op_E   out 4       registered ALU op
//  opcode_E   out 6       registered opcode (ALU uses it for BNE)
//  ctrl_E     out 4       {reg_write,mem_read,mem_write,mem_to_reg}
//  dst_E      out 5       write-back register index
//  store_E    out DATA_W  forwarded rt value for SW
//  stall_D    out 1       hold PC and IF/ID; ID/EX takes a bubble
// BEHAVIOUR
//  - Reset or bubble: all registers 0, so ctrl_E=0, dst_E=0, alu_op_E=ADD, opcode_E=0.
//    The comb outputs follow: reg_A=reg_B=0, store_E=0, stall_D=0.
//  - Each edge picks one source, priority RESET > flush_E > stall_D > latch ID fields
//    (invalid ID latches a bubble).
//  - Latency: one cycle from ID to registered E fields; reg_A/reg_B/store_E comb from E regs + fwd.
//  - Forwarding of E.rs/E.rt: idx==0 -> 0. Else exm_wr&&exm_rd==idx -> exm_res.
//    Else mwb_wr&&mwb_rd==idx -> mwb_data. Else latched data. EX/MEM beats MEM/WB.
//  - reg_A: SLL/SRL/SRA (funct 00/02/03) -> {27'b0,shamt}; SLLV/SRLV/SRAV -> fwd rs; LUI -> 0.
//    Otherwise fwd rs.
//  - reg_B: alu_src=0 -> fwd rt; ANDI/ORI/XORI -> zero-ext imm; LUI(0x0F) -> imm<<16 (alu_op forced ADD).
//    Other alu_src=1 -> sign-ext imm.
//  - dst_E: R-type (opcode 0) rd; JAL 31; else rt.
//  - store_E = fwd rt regardless of alu_src.
//  - stall_D = valid_D && ctrl_E.mem_read && dst_E!=0 && (dst_E==rs_D || (dst_E==rt_D && rt used)).
//    rt is used by R-type, SW, BEQ, BNE.
//  - Stall is exactly one cycle: the next E state is a bubble, so stall_D drops.
//  - flush_E with stall_D: flush wins, bubble latched, stall irrelevant next cycle.
//  - RESET mid-stall: all cleared, stall_D=0 next cycle.
// STRUCTURE
//  - Shared package cpu_defs: ALU_OP_* codes (ADD=0..SRA=9), OP_* opcodes, FUNCT_* codes,
//    ctrl bit indices.
//  - Sub-module fwd_mux, instantiated twice (rs, rt): idx, latched data, two sources -> value.
//  - Rest is one always block for the pipeline register plus comb operand logic.
// TESTING
//  - Reset: RESET=1 two cycles -> all outputs 0, stall_D=0; first valid ADD latched next edge.
//  - Forward priority: E.rs=8, exm_rd=8 res=0x11, mwb_rd=8 data=0x22 -> reg_A=0x11.
//    With exm_wr=0 -> 0x22. With rs=0 -> 0.
//  - Shift/imm: SRA shamt=4 -> reg_A=4. ORI imm=0x8000 -> reg_B=0x00008000.
//    ADDI imm=0x8000 -> 0xFFFF8000. LUI 0x1234 -> reg_B=0x12340000, reg_A=0.
//  - Load-use: LW $t0 in E, ADD rs=$t0 in ID -> stall_D=1 one cycle, next E is bubble, then ADD latches.
//    SW with rt=$t0 also stalls.
//  - Flush vs stall: flush_E=1 during load-use stall -> ctrl_E=0 next cycle, stall_D=0.
//  - BNE: opcode 0x05 latched -> opcode_E=0x05, rs/rt forwarded to reg_A/reg_B, alu_op_E=SUB.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings for the ID/EX stage and its neighbours.
//   - ALU operation codes driven on alu_op_E (ADD is code 0, so a bubble
//     naturally presents ADD to the ALU).
//   - MIPS primary opcodes (instr[31:26]) and R-type funct codes (instr[5:0]).
//   - Bit positions inside the 5-bit decoder control bundle ctrl_D.
//   - rt_is_source(): whether an instruction reads rt as a register operand.
package cpu_defs;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_OR  = 4'd3,
        ALU_OP_XOR = 4'd4,
        ALU_OP_NOR = 4'd5,
        ALU_OP_SLT = 4'd6,
        ALU_OP_SLL = 4'd7,
        ALU_OP_SRL = 4'd8,
        ALU_OP_SRA = 4'd9
    } alu_op_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FUNCT_SLL  = 6'h00,
        FUNCT_SRL  = 6'h02,
        FUNCT_SRA  = 6'h03,
        FUNCT_SLLV = 6'h04,
        FUNCT_SRLV = 6'h06,
        FUNCT_SRAV = 6'h07,
        FUNCT_ADD  = 6'h20,
        FUNCT_SUB  = 6'h22,
        FUNCT_AND  = 6'h24,
        FUNCT_OR   = 6'h25,
        FUNCT_XOR  = 6'h26,
        FUNCT_NOR  = 6'h27,
        FUNCT_SLT  = 6'h2A
    } funct_e;

    // ctrl_D = {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_ALU_SRC    = 0;

    // rt is a source operand for R-type ALU ops, stores (data) and branches
    // (compare). For I-type ALU ops and loads it is only a destination.
    function automatic logic rt_is_source(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: operand bypass selector for one register operand of the EX stage.
//   idx      register index held in ID/EX
//   latched  register-file value captured in ID
//   exm_*    EX/MEM result (newest, wins over MEM/WB)
//   mwb_*    MEM/WB write-back data
//   value    operand the ALU should see
// Register 0 is hard-wired to zero, so it is never bypassed.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] latched,
    input  logic              exm_wr,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_res,
    input  logic              mwb_wr,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] value
);

    always_comb begin
        value = latched;
        if (idx == '0) begin
            value = '0;
        end else if (exm_wr && (exm_rd == idx)) begin
            value = exm_res;
        end else if (mwb_wr && (mwb_rd == idx)) begin
            value = mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX-stage operand builder.
//   CLK, RESET               rising-edge clock, synchronous active-high reset
//   valid_D + *_D fields     decoded instruction presented by ID
//   flush_E                  redirect: discard whatever would enter EX
//   exm_*, mwb_*             bypass sources from EX/MEM and MEM/WB
//   reg_A, reg_B             ALU operands (reg_A carries shamt for shifts)
//   alu_op_E, opcode_E       registered ALU op and opcode
//   ctrl_E                   {reg_write, mem_read, mem_write, mem_to_reg}
//   dst_E                    write-back register index
//   store_E                  bypassed rt value for stores
//   stall_D                  load-use hazard: ID must hold, EX takes a bubble
//
// Handshake: valid_D qualifies the ID fields on every edge. stall_D is the
// back-pressure signal; while it is high the instruction in ID is not taken
// and ID must present the same instruction again on the next cycle.
module id_ex_stage
    import cpu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              valid_D,
    input  logic [5:0]        opcode_D,
    input  logic [5:0]        funct_D,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic [REG_AW-1:0] rd_D,
    input  logic [4:0]        shamt_D,
    input  logic [15:0]       imm_D,
    input  logic [DATA_W-1:0] rs_data_D,
    input  logic [DATA_W-1:0] rt_data_D,
    input  logic [3:0]        alu_op_D,
    input  logic [4:0]        ctrl_D,
    input  logic              flush_E,
    input  logic              exm_wr,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_res,
    input  logic              mwb_wr,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] reg_A,
    output logic [DATA_W-1:0] reg_B,
    output logic [3:0]        alu_op_E,
    output logic [5:0]        opcode_E,
    output logic [3:0]        ctrl_E,
    output logic [REG_AW-1:0] dst_E,
    output logic [DATA_W-1:0] store_E,
    output logic              stall_D
);

    logic [5:0]        opcode_q,  opcode_d;
    logic [5:0]        funct_q,   funct_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dst_q,     dst_d;
    logic [4:0]        shamt_q,   shamt_d;
    logic [15:0]       imm_q,     imm_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [3:0]        alu_op_q,  alu_op_d;
    logic [4:0]        ctrl_q,    ctrl_d;

    // ---------------- load-use hazard ----------------
    always_comb begin
        stall_D = valid_D && ctrl_q[CTRL_MEM_READ] && (dst_q != '0) &&
                  ((dst_q == rs_D) || ((dst_q == rt_D) && rt_is_source(opcode_D)));
    end

    // ---------------- next ID/EX contents ----------------
    // Default is a bubble (all zero); only an unflushed, unstalled, valid
    // instruction is captured. RESET is applied in the flop block.
    always_comb begin
        opcode_d  = '0;
        funct_d   = '0;
        rs_d      = '0;
        rt_d      = '0;
        dst_d     = '0;
        shamt_d   = '0;
        imm_d     = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        alu_op_d  = ALU_OP_ADD;
        ctrl_d    = '0;
        if (!flush_E && !stall_D && valid_D) begin
            opcode_d  = opcode_D;
            funct_d   = funct_D;
            rs_d      = rs_D;
            rt_d      = rt_D;
            shamt_d   = shamt_D;
            imm_d     = imm_D;
            rs_data_d = rs_data_D;
            rt_data_d = rt_data_D;
            ctrl_d    = ctrl_D;
            // LUI is built as 0 + (imm << 16), so the ALU must add.
            alu_op_d  = (opcode_D == OP_LUI) ? ALU_OP_ADD : alu_op_D;
            if (opcode_D == OP_RTYPE) begin
                dst_d = rd_D;
            end else if (opcode_D == OP_JAL) begin
                dst_d = {REG_AW{1'b1}};
            end else begin
                dst_d = rt_D;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            opcode_q  <= '0;
            funct_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            shamt_q   <= '0;
            imm_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            alu_op_q  <= ALU_OP_ADD;
            ctrl_q    <= '0;
        end else begin
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            shamt_q   <= shamt_d;
            imm_q     <= imm_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            alu_op_q  <= alu_op_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // ---------------- operand bypass ----------------
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx      (rs_q),
        .latched  (rs_data_q),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_res  (exm_res),
        .mwb_wr   (mwb_wr),
        .mwb_rd   (mwb_rd),
        .mwb_data (mwb_data),
        .value    (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx      (rt_q),
        .latched  (rt_data_q),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_res  (exm_res),
        .mwb_wr   (mwb_wr),
        .mwb_rd   (mwb_rd),
        .mwb_data (mwb_data),
        .value    (rt_fwd)
    );

    // ---------------- ALU operand build ----------------
    logic shift_by_shamt;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;

    always_comb begin
        // Only the constant-shift forms take shamt; the *V forms shift by rs.
        shift_by_shamt = (opcode_q == OP_RTYPE) &&
                         ((funct_q == FUNCT_SLL) || (funct_q == FUNCT_SRL) ||
                          (funct_q == FUNCT_SRA));
        imm_zext = {{(DATA_W-16){1'b0}}, imm_q};
        imm_sext = {{(DATA_W-16){imm_q[15]}}, imm_q};

        if (shift_by_shamt) begin
            reg_A = {{(DATA_W-5){1'b0}}, shamt_q};
        end else if (opcode_q == OP_LUI) begin
            reg_A = '0;
        end else begin
            reg_A = rs_fwd;
        end

        if (!ctrl_q[CTRL_ALU_SRC]) begin
            reg_B = rt_fwd;
        end else begin
            case (opcode_q)
                OP_ANDI, OP_ORI, OP_XORI: reg_B = imm_zext;
                OP_LUI:                   reg_B = imm_zext << 16;
                default:                  reg_B = imm_sext;
            endcase
        end
    end

    assign store_E  = rt_fwd;
    assign alu_op_E = alu_op_q;
    assign opcode_E = opcode_q;
    assign dst_E    = dst_q;
    assign ctrl_E   = {ctrl_q[CTRL_REG_WRITE], ctrl_q[CTRL_MEM_READ],
                       ctrl_q[CTRL_MEM_WRITE], ctrl_q[CTRL_MEM_TO_REG]};

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Each step drives ID/forwarding inputs,
// pushes the outputs it requires onto exp_q, and compares them against the
// DUT mid-cycle.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic              valid_D;
    logic [5:0]        opcode_D, funct_D;
    logic [4:0]        rs_D, rt_D, rd_D, shamt_D;
    logic [15:0]       imm_D;
    logic [31:0]       rs_data_D, rt_data_D;
    logic [3:0]        alu_op_D;
    logic [4:0]        ctrl_D;
    logic              flush_E;
    logic              exm_wr, mwb_wr;
    logic [4:0]        exm_rd, mwb_rd;
    logic [31:0]       exm_res, mwb_data;
    logic [31:0]       reg_A, reg_B, store_E;
    logic [3:0]        alu_op_E, ctrl_E;
    logic [5:0]        opcode_E;
    logic [4:0]        dst_E;
    logic              stall_D;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .CLK(CLK), .RESET(RESET), .valid_D(valid_D),
        .opcode_D(opcode_D), .funct_D(funct_D),
        .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D), .shamt_D(shamt_D),
        .imm_D(imm_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
        .alu_op_D(alu_op_D), .ctrl_D(ctrl_D), .flush_E(flush_E),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .reg_A(reg_A), .reg_B(reg_B), .alu_op_E(alu_op_E),
        .opcode_E(opcode_E), .ctrl_E(ctrl_E), .dst_E(dst_E),
        .store_E(store_E), .stall_D(stall_D)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        logic [31:0] a, b, st;
        logic [3:0]  op;
        logic [5:0]  opc;
        logic [3:0]  ctrl;
        logic [4:0]  dst;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // ---------------- driver tasks ----------------
    task automatic drive_id(input logic [5:0] opc, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [31:0] rsd,
                            input logic [31:0] rtd, input logic [3:0] aop,
                            input logic [4:0] ctrl);
        valid_D = 1'b1; opcode_D = opc; funct_D = fn;
        rs_D = rs; rt_D = rt; rd_D = rd; shamt_D = sh; imm_D = imm;
        rs_data_D = rsd; rt_data_D = rtd; alu_op_D = aop; ctrl_D = ctrl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mdat);
        exm_wr = ew; exm_rd = erd; exm_res = eres;
        mwb_wr = mw; mwb_rd = mrd; mwb_data = mdat;
    endtask

    // Deassert valid but leave the fields, so a DUT ignoring valid_D shows up.
    task automatic idle_id();
        valid_D = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [3:0] aop,
                        input logic [4:0] ctrl);
        drive_id(opc, fn, rs, rt, rd, sh, imm, rsd, rtd, aop, ctrl);
        tick();
        idle_id();
    endtask

    task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] st, input logic [3:0] op,
                              input logic [5:0] opc, input logic [3:0] ctrl,
                              input logic [4:0] dst, input logic stall);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.st = st; e.op = op;
        e.opc = opc; e.ctrl = ctrl; e.dst = dst; e.stall = stall;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp_v);
        end
    endtask

    task automatic check();
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1 entries");
        end else begin
            e = exp_q.pop_front();
            cmp(e.tag, "reg_A",    reg_A,             e.a);
            cmp(e.tag, "reg_B",    reg_B,             e.b);
            cmp(e.tag, "store_E",  store_E,           e.st);
            cmp(e.tag, "alu_op_E", {28'h0, alu_op_E}, {28'h0, e.op});
            cmp(e.tag, "opcode_E", {26'h0, opcode_E}, {26'h0, e.opc});
            cmp(e.tag, "ctrl_E",   {28'h0, ctrl_E},   {28'h0, e.ctrl});
            cmp(e.tag, "dst_E",    {27'h0, dst_E},    {27'h0, e.dst});
            cmp(e.tag, "stall_D",  {31'h0, stall_D},  {31'h0, e.stall});
        end
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [4:0] C_RTYPE = 5'b10000;  // reg_write
    localparam logic [4:0] C_IMM   = 5'b10001;  // reg_write, alu_src
    localparam logic [4:0] C_LW    = 5'b11011;  // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [4:0] C_SW    = 5'b00101;  // mem_write, alu_src
    localparam logic [4:0] C_BR    = 5'b00000;

    initial begin
        RESET   = 1'b1;
        flush_E = 1'b0;
        idle_id();
        // Valid ADD held in ID throughout reset: must not be captured.
        drive_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7, 4'd0, C_RTYPE);
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check();
        RESET = 1'b0;
        expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check();
        tick();
        idle_id();
        expect_out("first_add", 5, 7, 7, 0, 6'h00, 4'b1000, 3, 0);
        check();

        // Forward priority on rs and rt.
        load(6'h00, 6'h20, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 32'h99, 32'hAA, 4'd0, C_RTYPE);
        set_fwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
        expect_out("fwd_exm", 32'h11, 32'hAA, 32'hAA, 0, 6'h00, 4'b1000, 10, 0);
        check();
        set_fwd(1'b0, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
        expect_out("fwd_mwb", 32'h22, 32'hAA, 32'hAA, 0, 6'h00, 4'b1000, 10, 0);
        check();
        set_fwd(1'b1, 5'd9, 32'h33, 1'b0, 5'd8, 32'h22);
        expect_out("fwd_rt", 32'h99, 32'h33, 32'h33, 0, 6'h00, 4'b1000, 10, 0);
        check();
        load(6'h00, 6'h20, 5'd0, 5'd9, 5'd10, 5'd0, 16'h0, 32'h55, 32'hAA, 4'd0, C_RTYPE);
        set_fwd(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88);
        expect_out("fwd_zero", 0, 32'hAA, 32'hAA, 0, 6'h00, 4'b1000, 10, 0);
        check();

        // Shifts and immediates.
        load(6'h00, 6'h03, 5'd0, 5'd5, 5'd6, 5'd4, 16'h0, 32'h0, 32'h80000000, 4'd9, C_RTYPE);
        expect_out("sra", 4, 32'h80000000, 32'h80000000, 9, 6'h00, 4'b1000, 6, 0);
        check();
        load(6'h00, 6'h04, 5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 32'h3, 32'h1, 4'd7, C_RTYPE);
        expect_out("sllv", 3, 1, 1, 7, 6'h00, 4'b1000, 6, 0);
        check();
        load(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h8000, 32'h1, 32'h5, 4'd3, C_IMM);
        expect_out("ori", 1, 32'h00008000, 5, 3, 6'h0D, 4'b1000, 2, 0);
        check();
        load(6'h08, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 16'h8000, 32'h1, 32'h5, 4'd0, C_IMM);
        expect_out("addi", 1, 32'hFFFF8000, 5, 0, 6'h08, 4'b1000, 3, 0);
        check();
        load(6'h0F, 6'h00, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234, 32'hDEAD, 32'h44, 4'd3, C_IMM);
        expect_out("lui", 0, 32'h12340000, 32'h44, 0, 6'h0F, 4'b1000, 4, 0);
        check();
        load(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 4'd0, C_RTYPE);
        expect_out("jal", 0, 0, 0, 0, 6'h03, 4'b1000, 31, 0);
        check();
        load(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h12, 32'h34, 4'd1, C_BR);
        set_fwd(1'b1, 5'd2, 32'h56, 1'b0, 5'd0, 32'h0);
        expect_out("bne", 32'h12, 32'h56, 32'h56, 1, 6'h05, 4'b0000, 2, 0);
        check();

        // Load-use: LW $8 in EX, ADD rs=$8 in ID.
        load(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 16'h4, 32'h100, 32'h0, 4'd0, C_LW);
        drive_id(6'h00, 6'h20, 5'd8, 5'd2, 5'd9, 5'd0, 16'h0, 32'h10, 32'h20, 4'd0, C_RTYPE);
        expect_out("lw_stall", 32'h100, 4, 0, 0, 6'h23, 4'b1101, 8, 1);
        check();
        tick();
        expect_out("lw_bubble", 0, 0, 0, 0, 0, 0, 0, 0);
        check();
        tick();
        idle_id();
        expect_out("after_stall", 32'h10, 32'h20, 32'h20, 0, 6'h00, 4'b1000, 9, 0);
        check();

        // SW with rt=$8 stalls; ADDI with rt=$8 does not; flush beats stall.
        load(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 16'h4, 32'h100, 32'h0, 4'd0, C_LW);
        drive_id(6'h2B, 6'h00, 5'd3, 5'd8, 5'd0, 5'd0, 16'h0, 32'h30, 32'h40, 4'd0, C_SW);
        expect_out("sw_stall", 32'h100, 4, 0, 0, 6'h23, 4'b1101, 8, 1);
        check();
        drive_id(6'h08, 6'h00, 5'd3, 5'd8, 5'd0, 5'd0, 16'h1, 32'h30, 32'h40, 4'd0, C_IMM);
        expect_out("addi_nostall", 32'h100, 4, 0, 0, 6'h23, 4'b1101, 8, 0);
        check();
        drive_id(6'h00, 6'h20, 5'd8, 5'd2, 5'd9, 5'd0, 16'h0, 32'h10, 32'h20, 4'd0, C_RTYPE);
        flush_E = 1'b1;
        expect_out("flush_stall", 32'h100, 4, 0, 0, 6'h23, 4'b1101, 8, 1);
        check();
        tick();
        flush_E = 1'b0;
        expect_out("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0);
        check();
        // Flush alone with a valid ADD in ID.
        flush_E = 1'b1;
        tick();
        flush_E = 1'b0;
        expect_out("flush_only", 0, 0, 0, 0, 0, 0, 0, 0);
        check();
        // Invalid ID latches a bubble even with ADD fields present.
        idle_id();
        tick();
        expect_out("invalid_bubble", 0, 0, 0, 0, 0, 0, 0, 0);
        check();

        // Load to $0 never stalls.
        load(6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 16'h4, 32'h100, 32'h0, 4'd0, C_LW);
        drive_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd9, 5'd0, 16'h0, 32'h0, 32'h0, 4'd0, C_RTYPE);
        expect_out("lw_r0", 32'h100, 4, 0, 0, 6'h23, 4'b1101, 0, 0);
        check();

        // RESET in the middle of a stall.
        load(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 16'h4, 32'h100, 32'h0, 4'd0, C_LW);
        drive_id(6'h00, 6'h20, 5'd8, 5'd2, 5'd9, 5'd0, 16'h0, 32'h10, 32'h20, 4'd0, C_RTYPE);
        expect_out("rst_pre", 32'h100, 4, 0, 0, 6'h23, 4'b1101, 8, 1);
        check();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        expect_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        check();

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain observed=%0d expected=0 entries", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
